// File: rtl/adc_sample_scheduler.sv
// ADC scan sequencer. Each sample tick starts a frame that walks the
// channels in order. For every channel it drives the channel select,
// lets it settle, then holds chip select low until the SPI receiver
// delivers a word or a timeout abandons that channel.
module adc_sample_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int SAMPLE_DIV     = 2660,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] adc_data,
  input  logic        adc_received,
  output logic        adc_cs_n,
  output logic [2:0]  adc_channel,
  output logic [15:0] sample_out,
  output logic [2:0]  sample_channel,
  output logic        sample_valid,
  output logic        frame_done,
  output logic        overrun,
  output logic [7:0]  timeout_count
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        LAST_CH     = 3'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    CONVERT = 2'd2,
    NEXT    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [2:0]        index_q, index_d;
  logic              rx_prev_q;
  logic              cs_n_q, cs_n_d;
  logic [15:0]       sample_q, sample_d;
  logic [2:0]        sample_ch_q, sample_ch_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        to_count_q, to_count_d;

  logic tick;
  logic rx_edge;

  // The tick fires on the last count of the divider; a rising strobe is
  // judged against the previous level, which is tracked in every state so a
  // level that was already high before CONVERT never looks like a new word.
  assign tick    = enable && (tick_cnt_q == TICK_LAST);
  assign rx_edge = adc_received && !rx_prev_q;

  // Next-state and registered-output computation for the scan sequencer.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = '0;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;
    index_d      = index_q;
    sample_d     = sample_q;
    sample_ch_d  = sample_ch_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    overrun_d    = tick && (state_q != IDLE);
    to_count_d   = to_count_q;

    if (enable) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          index_d      = 3'd0;
          settle_cnt_d = '0;
          state_d      = SELECT;
        end
      end
      SELECT: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          to_cnt_d = '0;
          state_d  = CONVERT;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      CONVERT: begin
        // A word arriving on the expiry cycle still counts as a sample.
        if (rx_edge) begin
          sample_d    = adc_data;
          sample_ch_d = index_q;
          valid_d     = 1'b1;
          done_d      = (index_q == LAST_CH);
          state_d     = NEXT;
        end else if (to_cnt_q == TO_LAST) begin
          if (to_count_q != 8'hFF) begin
            to_count_d = to_count_q + 8'd1;
          end
          done_d  = (index_q == LAST_CH);
          state_d = NEXT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      NEXT: begin
        if (index_q == LAST_CH) begin
          state_d = IDLE;
        end else begin
          index_d      = index_q + 3'd1;
          settle_cnt_d = '0;
          state_d      = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable abandons the frame with no partial results reported.
    if (!enable) begin
      state_d     = IDLE;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      sample_d    = sample_q;
      sample_ch_d = sample_ch_q;
      to_count_d  = to_count_q;
    end

    cs_n_d = (state_d != CONVERT);
  end

  // State, counters and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      index_q      <= 3'd0;
      rx_prev_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      sample_q     <= 16'd0;
      sample_ch_q  <= 3'd0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      to_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
      index_q      <= index_d;
      rx_prev_q    <= adc_received;
      cs_n_q       <= cs_n_d;
      sample_q     <= sample_d;
      sample_ch_q  <= sample_ch_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      to_count_q   <= to_count_d;
    end
  end

  assign adc_cs_n       = cs_n_q;
  assign adc_channel    = index_q;
  assign sample_out     = sample_q;
  assign sample_channel = sample_ch_q;
  assign sample_valid   = valid_q;
  assign frame_done     = done_q;
  assign overrun        = overrun_q;
  assign timeout_count  = to_count_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: reset, normal frame, timeout
// recovery, overrun, enable abort and stale receive strobe.
module tb_adc_sample_scheduler;

  localparam int NCH  = 3;
  localparam int SETL = 4;
  localparam int DIV  = 400;
  localparam int TOC  = 200;
  // cycles from enable (set just before the first edge) to the first cs_n fall
  localparam int FIRST_FALL = DIV + SETL;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] adc_data = 16'h0000;
  logic        adc_received = 1'b0;
  logic        adc_cs_n;
  logic [2:0]  adc_channel;
  logic [15:0] sample_out;
  logic [2:0]  sample_channel;
  logic        sample_valid;
  logic        frame_done;
  logic        overrun;
  logic [7:0]  timeout_count;

  logic        en2 = 1'b0;
  logic        rx2 = 1'b0;
  logic [15:0] data2 = 16'h0000;
  logic        adc_cs_n_2;
  logic [2:0]  adc_channel_2;
  logic [15:0] sample_out_2;
  logic [2:0]  sample_channel_2;
  logic        sample_valid_2;
  logic        frame_done_2;
  logic        overrun_2;
  logic [7:0]  timeout_count_2;

  adc_sample_scheduler #(
    .NUM_CHANNELS(NCH), .SAMPLE_DIV(DIV), .SETTLE_CYCLES(SETL), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .adc_data(adc_data), .adc_received(adc_received),
    .adc_cs_n(adc_cs_n), .adc_channel(adc_channel),
    .sample_out(sample_out), .sample_channel(sample_channel),
    .sample_valid(sample_valid), .frame_done(frame_done),
    .overrun(overrun), .timeout_count(timeout_count)
  );

  adc_sample_scheduler #(
    .NUM_CHANNELS(NCH), .SAMPLE_DIV(16), .SETTLE_CYCLES(SETL), .TIMEOUT_CYCLES(TOC)
  ) dut_ovr (
    .clock(clock), .reset(reset), .enable(en2),
    .adc_data(data2), .adc_received(rx2),
    .adc_cs_n(adc_cs_n_2), .adc_channel(adc_channel_2),
    .sample_out(sample_out_2), .sample_channel(sample_channel_2),
    .sample_valid(sample_valid_2), .frame_done(frame_done_2),
    .overrun(overrun_2), .timeout_count(timeout_count_2)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0]  mon_ch[$];
  logic [15:0] mon_data[$];
  int          mon_done = 0;

  // one line per captured sample
  always @(negedge clock) begin
    if (reset === 1'b1 && sample_valid === 1'b1) begin
      mon_ch.push_back(sample_channel);
      mon_data.push_back(sample_out);
      $display("t=%0t sample ch=%0d data=%h frame_done=%b", $time, sample_channel, sample_out, frame_done);
    end
    if (reset === 1'b1 && frame_done === 1'b1) mon_done++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_cs_fall(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      if (adc_cs_n === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    adc_data     = w;
    adc_received = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    enable       = 1'b0;
    en2          = 1'b0;
    adc_received = 1'b0;
    rx2          = 1'b0;
    adc_data     = 16'h0000;
    wait_cycles(3);
    reset = 1'b1;
    mon_ch.delete();
    mon_data.delete();
    mon_done = 0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    wait_cycles(3);
    n_vec++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n: got %b expected 1", adc_cs_n); end
    n_vec++; if (adc_channel !== 3'd0) begin n_err++; $display("FAIL rst_channel: got %0d expected 0", adc_channel); end
    n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
    n_vec++; if (timeout_count !== 8'd0) begin n_err++; $display("FAIL rst_timeouts: got %0d expected 0", timeout_count); end
    reset  = 1'b1;
    enable = 1'b1;
    wait_cs_fall(1000, n);
    n_vec++; if (n != FIRST_FALL) begin n_err++; $display("FAIL rst_first_fall: got %0d expected %0d", n, FIRST_FALL); end
    wait_cycles(5);
    send_word(16'h1234);
    n_vec++; if (sample_out !== 16'h1234) begin n_err++; $display("FAIL rst_pre_sample: got %h expected 1234", sample_out); end
    adc_received = 1'b0;
    wait_cs_fall(1000, n);
    n_vec++; if (adc_channel !== 3'd1) begin n_err++; $display("FAIL rst_pre_channel: got %0d expected 1", adc_channel); end
    wait_cycles(3);
    #2 reset = 1'b0;
    #1;
    n_vec++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL async_cs_n: got %b expected 1", adc_cs_n); end
    n_vec++; if (adc_channel !== 3'd0) begin n_err++; $display("FAIL async_channel: got %0d expected 0", adc_channel); end
    n_vec++; if (sample_out !== 16'h0000) begin n_err++; $display("FAIL async_sample_out: got %h expected 0000", sample_out); end
    n_vec++; if (sample_channel !== 3'd0) begin n_err++; $display("FAIL async_sample_ch: got %0d expected 0", sample_channel); end
    n_vec++; if ({sample_valid, frame_done, overrun} !== 3'b000) begin n_err++; $display("FAIL async_pulses: got %b expected 000", {sample_valid, frame_done, overrun}); end
    n_vec++; if (timeout_count !== 8'd0) begin n_err++; $display("FAIL async_timeouts: got %0d expected 0", timeout_count); end
    @(negedge clock);
    reset = 1'b1;
    wait_cs_fall(1000, n);
    n_vec++; if (n != FIRST_FALL) begin n_err++; $display("FAIL rst_restart_fall: got %0d expected %0d", n, FIRST_FALL); end
    n_vec++; if (adc_channel !== 3'd0) begin n_err++; $display("FAIL rst_restart_ch: got %0d expected 0", adc_channel); end
  endtask

  task automatic test_normal_frame();
    int n;
    logic [15:0] words [3];
    words[0] = 16'hAACC; words[1] = 16'h1655; words[2] = 16'h96AA;
    do_reset();
    enable = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      wait_cs_fall(1000, n);
      n_vec++; if (n < 0) begin n_err++; $display("FAIL norm_cs_fall ch%0d: got none expected fall", ch); end
      n_vec++; if (adc_channel !== 3'(ch)) begin n_err++; $display("FAIL norm_channel: got %0d expected %0d", adc_channel, ch); end
      wait_cycles(5);
      send_word(words[ch]);
      n_vec++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL norm_valid ch%0d: got %b expected 1", ch, sample_valid); end
      n_vec++; if (sample_channel !== 3'(ch)) begin n_err++; $display("FAIL norm_tag: got %0d expected %0d", sample_channel, ch); end
      n_vec++; if (sample_out !== words[ch]) begin n_err++; $display("FAIL norm_data ch%0d: got %h expected %h", ch, sample_out, words[ch]); end
      n_vec++; if (frame_done !== (ch == NCH - 1)) begin n_err++; $display("FAIL norm_frame_done ch%0d: got %b expected %b", ch, frame_done, (ch == NCH - 1)); end
      n_vec++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL norm_cs_rise ch%0d: got %b expected 1", ch, adc_cs_n); end
      adc_received = 1'b0;
    end
  endtask

  task automatic test_truncated_word();
    int n;
    int low_cnt;
    logic [15:0] words [3];
    words[0] = 16'h0F0F; words[1] = 16'h3C3C; words[2] = 16'hC3C3;
    do_reset();
    enable = 1'b1;
    wait_cs_fall(1000, n);
    wait_cycles(5);
    send_word(16'hAACC);
    adc_received = 1'b0;
    // channel 1: receiver never completes the word
    wait_cs_fall(1000, n);
    low_cnt = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (adc_cs_n !== 1'b0) break;
      low_cnt++;
    end
    n_vec++; if (low_cnt != TOC) begin n_err++; $display("FAIL trunc_cs_low: got %0d cycles expected %0d", low_cnt, TOC); end
    n_vec++; if (timeout_count !== 8'd1) begin n_err++; $display("FAIL trunc_timeouts: got %0d expected 1", timeout_count); end
    n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL trunc_no_valid: got %b expected 0", sample_valid); end
    wait_cs_fall(1000, n);
    n_vec++; if (adc_channel !== 3'd2) begin n_err++; $display("FAIL trunc_ch2_select: got %0d expected 2", adc_channel); end
    wait_cycles(5);
    send_word(16'h96AA);
    n_vec++; if ({sample_valid, sample_channel, frame_done} !== {1'b1, 3'd2, 1'b1}) begin n_err++; $display("FAIL trunc_ch2_sample: got %b expected %b", {sample_valid, sample_channel, frame_done}, {1'b1, 3'd2, 1'b1}); end
    adc_received = 1'b0;
    wait_cycles(1);
    n_vec++; if (mon_ch.size() != 2) begin n_err++; $display("FAIL trunc_sample_count: got %0d expected 2", mon_ch.size()); end
    n_vec++; if (mon_ch.size() == 2 && (mon_ch[0] !== 3'd0 || mon_ch[1] !== 3'd2)) begin n_err++; $display("FAIL trunc_sample_tags: got %0d,%0d expected 0,2", mon_ch[0], mon_ch[1]); end
    // following frame is complete again
    for (int ch = 0; ch < NCH; ch++) begin
      wait_cs_fall(1000, n);
      wait_cycles(3);
      send_word(words[ch]);
      n_vec++; if ({sample_valid, sample_channel, sample_out} !== {1'b1, 3'(ch), words[ch]}) begin n_err++; $display("FAIL trunc_next_frame ch%0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h", ch, sample_valid, sample_channel, sample_out, ch, words[ch]); end
      adc_received = 1'b0;
    end
    n_vec++; if (timeout_count !== 8'd1) begin n_err++; $display("FAIL trunc_timeouts_hold: got %0d expected 1", timeout_count); end
  endtask

  task automatic test_overrun();
    int ovr;
    int seen_done;
    logic cs_prev;
    logic [2:0] ch_seen[$];
    do_reset();
    ovr = 0; seen_done = 0; cs_prev = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (overrun_2 === 1'b1) ovr++;
      if (cs_prev === 1'b1 && adc_cs_n_2 === 1'b0) ch_seen.push_back(adc_channel_2);
      cs_prev = adc_cs_n_2;
      if (frame_done_2 === 1'b1) begin
        seen_done = 1;
        break;
      end
    end
    n_vec++; if (seen_done != 1) begin n_err++; $display("FAIL ovr_frame_done: got %0d expected 1", seen_done); end
    n_vec++; if (ovr == 0) begin n_err++; $display("FAIL ovr_pulses: got %0d expected nonzero", ovr); end
    n_vec++; if (ch_seen.size() != 3) begin n_err++; $display("FAIL ovr_channel_count: got %0d expected 3", ch_seen.size()); end
    n_vec++; if (ch_seen.size() == 3 && (ch_seen[0] !== 3'd0 || ch_seen[1] !== 3'd1 || ch_seen[2] !== 3'd2)) begin n_err++; $display("FAIL ovr_channel_order: got %0d,%0d,%0d expected 0,1,2", ch_seen[0], ch_seen[1], ch_seen[2]); end
    n_vec++; if (timeout_count_2 !== 8'd3) begin n_err++; $display("FAIL ovr_timeouts: got %0d expected 3", timeout_count_2); end
    n_vec++; if (adc_cs_n_2 !== 1'b1) begin n_err++; $display("FAIL ovr_cs_rise: got %b expected 1", adc_cs_n_2); end
    en2 = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n;
    do_reset();
    enable = 1'b1;
    wait_cs_fall(1000, n);
    wait_cycles(5);
    send_word(16'h0101);
    adc_received = 1'b0;
    wait_cs_fall(1000, n);
    n_vec++; if (adc_channel !== 3'd1) begin n_err++; $display("FAIL drop_channel: got %0d expected 1", adc_channel); end
    wait_cycles(5);
    // abort together with a word arriving: the word must be ignored
    enable       = 1'b0;
    adc_data     = 16'hDEAD;
    adc_received = 1'b1;
    @(negedge clock);
    n_vec++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL drop_cs_n: got %b expected 1", adc_cs_n); end
    n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL drop_valid: got %b expected 0", sample_valid); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL drop_frame_done: got %b expected 0", frame_done); end
    wait_cycles(10);
    adc_received = 1'b0;
    wait_cycles(2);
    n_vec++; if (mon_ch.size() != 1 || mon_done != 0) begin n_err++; $display("FAIL drop_partial: got samples=%0d done=%0d expected samples=1 done=0", mon_ch.size(), mon_done); end
    n_vec++; if (sample_out !== 16'h0101) begin n_err++; $display("FAIL drop_sample_hold: got %h expected 0101", sample_out); end
    enable = 1'b1;
    wait_cs_fall(1000, n);
    n_vec++; if (n != FIRST_FALL) begin n_err++; $display("FAIL drop_restart_fall: got %0d expected %0d", n, FIRST_FALL); end
    n_vec++; if (adc_channel !== 3'd0) begin n_err++; $display("FAIL drop_restart_ch: got %0d expected 0", adc_channel); end
  endtask

  task automatic test_stale_strobe();
    int n;
    do_reset();
    adc_data     = 16'hBEEF;
    adc_received = 1'b1;
    enable       = 1'b1;
    wait_cs_fall(1000, n);
    n_vec++; if (n != FIRST_FALL) begin n_err++; $display("FAIL stale_fall: got %0d expected %0d", n, FIRST_FALL); end
    wait_cycles(10);
    n_vec++; if (mon_ch.size() != 0) begin n_err++; $display("FAIL stale_no_sample: got %0d samples expected 0", mon_ch.size()); end
    n_vec++; if (adc_cs_n !== 1'b0) begin n_err++; $display("FAIL stale_still_convert: got %b expected 0", adc_cs_n); end
    adc_received = 1'b0;
    @(negedge clock);
    send_word(16'h5A5A);
    n_vec++; if ({sample_valid, sample_channel, sample_out} !== {1'b1, 3'd0, 16'h5A5A}) begin n_err++; $display("FAIL stale_fresh_edge: got v=%b ch=%0d d=%h expected v=1 ch=0 d=5a5a", sample_valid, sample_channel, sample_out); end
    adc_received = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_truncated_word();
    test_overrun();
    test_enable_drop();
    test_stale_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
